// File: rtl/avg_pool2d_stream_ctrl_pkg.sv
// Shared types and elaboration helpers for the average-pool stream controller.
package pool_ctrl_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } pool_state_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  // Enough headroom to sum AREA full-scale samples without overflow.
  function automatic int acc_width(input int p, input int area);
    return p + $clog2(area);
  endfunction

endpackage

// File: rtl/avg_pool2d_stream_ctrl_if.sv
// Single-lane valid/ready pixel stream; data is a one-element unpacked array.
interface avg_pool2d_stream_ctrl_if #(
  parameter int P = 8
);
  logic [P-1:0] data [1];
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/avg_pool2d_stream_ctrl_round_shift.sv
// Signed divide by 2**SHIFT with round toward zero, narrowed to RES_W bits.
module avg_round_shift #(
  parameter int ACC_W = 10,
  parameter int RES_W = 8,
  parameter int SHIFT = 2
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [RES_W-1:0] o_mean
);
  localparam logic signed [ACC_W-1:0] BIAS = ACC_W'((1 << SHIFT) - 1);

  logic signed [ACC_W-1:0] w_biased;

  // Biasing negatives turns the floor of >>> into truncation toward zero.
  assign w_biased = i_acc[ACC_W-1] ? (i_acc + BIAS) : i_acc;
  assign o_mean   = RES_W'(w_biased >>> SHIFT);
endmodule

// File: rtl/avg_pool2d_stream_ctrl.sv
// Raster-scan 2-D average pooling: accumulates one band of windows, then
// drains one rounded mean per output handshake while holding off input.
//   state | meaning
//   ACCUM | accept pixels, add in-region pixels into acc[col/KW]
//   DRAIN | present acc[oc]/AREA, one result per output handshake
module avg_pool2d_stream_ctrl
  import pool_ctrl_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0 = 8,
  parameter int DATA_IN_0_PRECISION_1 = 3,
  parameter int DATA_IN_0_WIDTH       = 8,
  parameter int DATA_IN_0_HEIGHT      = 8,
  parameter int KERNEL_WIDTH          = 2,
  parameter int KERNEL_HEIGHT         = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  avg_pool2d_stream_ctrl_if.slave     data_in_0,
  avg_pool2d_stream_ctrl_if.master    data_out_0
);
  localparam int P       = DATA_IN_0_PRECISION_0;
  localparam int IN_W    = DATA_IN_0_WIDTH;
  localparam int IN_H    = DATA_IN_0_HEIGHT;
  localparam int KW      = KERNEL_WIDTH;
  localparam int KH      = KERNEL_HEIGHT;
  localparam int OUT_W   = IN_W / KW;
  localparam int OUT_H   = IN_H / KH;
  localparam int AREA    = KW * KH;
  localparam int SH      = $clog2(AREA);
  localparam int ACC_W   = acc_width(P, AREA);
  localparam int COL_LIM = OUT_W * KW;
  localparam int ROW_LIM = OUT_H * KH;
  localparam int COL_W   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int ROW_W   = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int KR_W    = (KH > 1) ? $clog2(KH) : 1;
  localparam int OC_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  if (!is_pow2(AREA)) begin : g_area_chk
    $error("KERNEL_WIDTH*KERNEL_HEIGHT must be a power of two");
  end
  if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_frac_chk
    $error("fractional bits exceed sample width");
  end

  pool_state_e              r_state, w_state_nxt;
  logic [COL_W-1:0]         r_col;
  logic [ROW_W-1:0]         r_row;
  logic [KR_W-1:0]          r_kr;
  logic [OC_W-1:0]          r_oc;
  logic signed [ACC_W-1:0]  r_acc [OUT_W];

  logic                     w_in_hs, w_out_hs;
  logic                     w_col_last, w_row_last, w_kr_last, w_oc_last;
  logic                     w_in_region, w_band_done;
  logic [OC_W-1:0]          w_win;
  logic signed [ACC_W-1:0]  w_px_ext, w_acc_sel;
  logic signed [P-1:0]      w_mean;

  assign w_in_hs     = data_in_0.valid && (r_state == ACCUM);
  assign w_out_hs    = data_out_0.ready && (r_state == DRAIN);
  assign w_col_last  = (int'(r_col) == IN_W - 1);
  assign w_row_last  = (int'(r_row) == IN_H - 1);
  assign w_kr_last   = (int'(r_kr) == KH - 1);
  assign w_oc_last   = (int'(r_oc) == OUT_W - 1);
  assign w_in_region = (int'(r_col) < COL_LIM) && (int'(r_row) < ROW_LIM);
  assign w_band_done = (int'(r_col) == COL_LIM - 1) && w_kr_last && (int'(r_row) < ROW_LIM);
  assign w_win       = OC_W'(int'(r_col) / KW);
  assign w_px_ext    = ACC_W'($signed(data_in_0.data[0]));
  assign w_acc_sel   = r_acc[r_oc];

  avg_round_shift #(
    .ACC_W (ACC_W),
    .RES_W (P),
    .SHIFT (SH)
  ) u_round (
    .i_acc  (w_acc_sel),
    .o_mean (w_mean)
  );

  assign data_in_0.ready    = (r_state == ACCUM);
  assign data_out_0.valid   = (r_state == DRAIN);
  assign data_out_0.data[0] = (r_state == DRAIN) ? w_mean : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ACCUM;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_in_hs && w_band_done) w_state_nxt = DRAIN;
      DRAIN:   if (w_out_hs && w_oc_last)  w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
      r_kr  <= '0;
    end else if (w_in_hs) begin
      if (w_col_last) begin
        r_col <= '0;
        if (w_row_last) begin
          r_row <= '0;
          r_kr  <= '0;
        end else begin
          r_row <= r_row + ROW_W'(1);
          r_kr  <= w_kr_last ? '0 : r_kr + KR_W'(1);
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Drained entries clear as they go, so the next band starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_oc <= '0;
      for (int i = 0; i < OUT_W; i++) r_acc[i] <= '0;
    end else if (w_out_hs) begin
      r_acc[r_oc] <= '0;
      r_oc        <= w_oc_last ? '0 : r_oc + OC_W'(1);
    end else if (w_in_hs && w_in_region) begin
      r_acc[w_win] <= r_acc[w_win] + w_px_ext;
    end
  end
endmodule

// File: tb/tb_avg_pool2d_stream_ctrl.sv
// Directed bench: 4x4 and 5x5 pooling instances with hand-computed means.
module tb_avg_pool2d_stream_ctrl;
  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] aq[$];
  logic [7:0] bq[$];
  logic [7:0] exp_q[$];
  logic [7:0] pix[$];

  avg_pool2d_stream_ctrl_if #(.P(8)) a_in ();
  avg_pool2d_stream_ctrl_if #(.P(8)) a_out ();
  avg_pool2d_stream_ctrl_if #(.P(8)) b_in ();
  avg_pool2d_stream_ctrl_if #(.P(8)) b_out ();

  avg_pool2d_stream_ctrl #(
    .DATA_IN_0_PRECISION_0 (8),
    .DATA_IN_0_PRECISION_1 (3),
    .DATA_IN_0_WIDTH       (4),
    .DATA_IN_0_HEIGHT      (4),
    .KERNEL_WIDTH          (2),
    .KERNEL_HEIGHT         (2)
  ) dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .data_in_0  (a_in),
    .data_out_0 (a_out)
  );

  avg_pool2d_stream_ctrl #(
    .DATA_IN_0_PRECISION_0 (8),
    .DATA_IN_0_PRECISION_1 (3),
    .DATA_IN_0_WIDTH       (5),
    .DATA_IN_0_HEIGHT      (5),
    .KERNEL_WIDTH          (2),
    .KERNEL_HEIGHT         (2)
  ) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .data_in_0  (b_in),
    .data_out_0 (b_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_out.valid && a_out.ready) aq.push_back(a_out.data[0]);
    if (b_out.valid && b_out.ready) bq.push_back(b_out.data[0]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int d, input logic [7:0] v, output int waits);
    waits = 0;
    if (d == 0) begin a_in.data[0] = v; a_in.valid = 1'b1; end
    else        begin b_in.data[0] = v; b_in.valid = 1'b1; end
    @(negedge clk);
    while (((d == 0) ? a_in.ready : b_in.ready) !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk); #1;
    if (d == 0) a_in.valid = 1'b0;
    else        b_in.valid = 1'b0;
  endtask

  task automatic send_range(input int d, input int lo, input int hi);
    int w;
    for (int i = lo; i <= hi; i++) begin
      send(d, pix[i], w);
      chk("send_wait_bound", 32'(w < 50), 32'd1);
    end
  endtask

  task automatic chk_q(input string tag, input int d);
    logic [7:0] q[$];
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    if (d == 0) begin q = aq; aq.delete(); end
    else        begin q = bq; bq.delete(); end
    chk({tag, "_count"}, q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  task automatic load_ramp(input int n, input int reps);
    pix.delete();
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < n; i++) pix.push_back(8'(i));
  endtask

  initial begin
    int w;
    int wsum;
    a_in.valid = 1'b0; a_in.data[0] = '0; a_out.ready = 1'b1;
    b_in.valid = 1'b0; b_in.data[0] = '0; b_out.ready = 1'b1;
    #1 rst_a = 1'b0; rst_b = 1'b0;
    #2;
    chk("rst_a_in_ready", a_in.ready, 1);
    chk("rst_a_out_valid", a_out.valid, 0);
    chk("rst_a_out_data", a_out.data[0], 0);
    chk("rst_b_in_ready", b_in.ready, 1);
    chk("rst_b_out_valid", b_out.valid, 0);
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1;

    // ramp 0..15, first result one cycle after pixel 7
    load_ramp(16, 1);
    send_range(0, 0, 6);
    chk("t1_pre_band_valid", a_out.valid, 0);
    send_range(0, 7, 7);
    @(negedge clk);
    chk("t1_lat_valid", a_out.valid, 1);
    chk("t1_lat_data", a_out.data[0], 8'd2);
    chk("t1_lat_in_ready", a_in.ready, 0);
    @(posedge clk); #1;
    send_range(0, 8, 15);
    exp_q = {8'd2, 8'd4, 8'd10, 8'd12};
    chk_q("t1_ramp", 0);

    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(8'hFD);
    send_range(0, 0, 15);
    exp_q = {8'hFD, 8'hFD, 8'hFD, 8'hFD};
    chk_q("t2_neg3", 0);

    pix = {8'hFF, 8'hFE, 8'h05, 8'h07,
           8'h00, 8'h00, 8'hFA, 8'hFF,
           8'hF8, 8'hF8, 8'hF8, 8'hF9,
           8'hF8, 8'hF8, 8'hF8, 8'hF8};
    send_range(0, 0, 15);
    exp_q = {8'h00, 8'h01, 8'hF8, 8'hF9};
    chk_q("t2_round", 0);

    pix = {8'h80, 8'h80, 8'h7F, 8'h7F,
           8'h80, 8'h80, 8'h7F, 8'h7F,
           8'h7F, 8'h7F, 8'h80, 8'h80,
           8'h7F, 8'h7E, 8'h80, 8'h81};
    send_range(0, 0, 15);
    exp_q = {8'h80, 8'h7F, 8'h7E, 8'h81};
    chk_q("t2_extreme", 0);

    // consumer stalls with a pixel waiting on the input
    load_ramp(16, 1);
    a_out.ready = 1'b0;
    send_range(0, 0, 7);
    a_in.data[0] = 8'd8; a_in.valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", a_out.valid, 1);
      chk("t3_hold_data", a_out.data[0], 8'd2);
      chk("t3_hold_in_ready", a_in.ready, 0);
    end
    @(posedge clk); #1; a_out.ready = 1'b1;
    @(posedge clk); #1; a_out.ready = 1'b0;
    @(negedge clk);
    chk("t3_next_valid", a_out.valid, 1);
    chk("t3_next_data", a_out.data[0], 8'd4);
    @(posedge clk); #1; a_out.ready = 1'b1;
    send_range(0, 8, 15);
    exp_q = {8'd2, 8'd4, 8'd10, 8'd12};
    chk_q("t3_backpressure", 0);

    load_ramp(16, 2);
    send_range(0, 0, 31);
    exp_q = {8'd2, 8'd4, 8'd10, 8'd12, 8'd2, 8'd4, 8'd10, 8'd12};
    chk_q("t4_two_frames", 0);

    // reset while oc == 1 in the drain
    load_ramp(16, 1);
    a_out.ready = 1'b0;
    send_range(0, 0, 7);
    a_out.ready = 1'b1;
    @(posedge clk); #1; a_out.ready = 1'b0;
    @(negedge clk);
    chk("t5_oc1_data", a_out.data[0], 8'd4);
    #1 rst_a = 1'b0;
    #1;
    chk("t5_rst_valid", a_out.valid, 0);
    chk("t5_rst_in_ready", a_in.ready, 1);
    chk("t5_rst_data", a_out.data[0], 0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    aq.delete();
    a_out.ready = 1'b1;
    send_range(0, 0, 15);
    exp_q = {8'd2, 8'd4, 8'd10, 8'd12};
    chk_q("t5_after_rst", 0);

    // 5x5: trailing column and row accepted without effect
    load_ramp(25, 1);
    send_range(1, 0, 19);
    wsum = 0;
    for (int i = 20; i < 25; i++) begin
      send(1, pix[i], w);
      wsum += w;
    end
    chk("b_row4_no_wait", wsum, 0);
    exp_q = {8'd3, 8'd5, 8'd13, 8'd15};
    chk_q("b_5x5", 1);
    send_range(1, 0, 24);
    chk_q("b_5x5_frame2", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
